// File: rtl/ifu_pc_ir.sv
// ============================================================================
// Module   : ifu_pc_ir
// Brief    : Multicycle fetch unit. Holds the PC, the instruction register and
//            the instruction counter, and decodes the IR fields.
//            Optional macro IFU_ALIGN_CHK_EN blocks misaligned targets and
//            raises a sticky align_err flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_pc_ir (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWr,
  input  logic        IRWr,
  input  logic [1:0]  NPCOp,
  input  logic        Zero,
  input  logic [31:0] rs_data,
  input  logic [31:0] im_dout,
  output logic [31:0] im_addr,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic [5:0]  op,
  output logic [5:0]  fun,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16,
  output logic [31:0] link,
  output logic [31:0] instr_cnt,
  output logic        align_err
);

  localparam logic [31:0] PC_RESET   = 32'h0000_3000;
  localparam logic [1:0]  NPC_SEQ    = 2'b00;
  localparam logic [1:0]  NPC_BRANCH = 2'b01;
  localparam logic [1:0]  NPC_JUMP   = 2'b10;

  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;
  logic [31:0] branch_off;
  logic [31:0] npc;

  // Branch and jump bases are the current pc, which the fetch already advanced.
  always_comb begin
    branch_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
    case (NPCOp)
      NPC_SEQ:    npc = pc_q + 32'd4;
      NPC_BRANCH: npc = Zero ? (pc_q + branch_off) : pc_q;
      NPC_JUMP:   npc = {pc_q[31:28], ir_q[25:0], 2'b00};
      default:    npc = rs_data;
    endcase
  end

  always_comb begin
    ir_d        = ir_q;
    instr_cnt_d = instr_cnt_q;
    if (IRWr) begin
      ir_d        = im_dout;
      instr_cnt_d = instr_cnt_q + 32'd1;
    end
  end

`ifdef IFU_ALIGN_CHK_EN
  logic align_err_q, align_err_d;

  always_comb begin
    pc_d        = pc_q;
    align_err_d = align_err_q;
    if (PCWr) begin
      if (npc[1:0] != 2'b00) align_err_d = 1'b1;
      else                   pc_d        = npc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) align_err_q <= 1'b0;
    else     align_err_q <= align_err_d;
  end

  assign align_err = align_err_q;
`else
  always_comb begin
    pc_d = pc_q;
    if (PCWr) pc_d = npc & 32'hFFFF_FFFC;
  end

  assign align_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= PC_RESET;
      ir_q        <= 32'd0;
      instr_cnt_q <= 32'd0;
    end else begin
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign pc        = pc_q;
  assign im_addr   = pc_q;
  assign link      = pc_q;
  assign ir        = ir_q;
  assign instr_cnt = instr_cnt_q;
  assign op        = ir_q[31:26];
  assign fun       = ir_q[5:0];
  assign rs        = ir_q[25:21];
  assign rt        = ir_q[20:16];
  assign rd        = ir_q[15:11];
  assign imm16     = ir_q[15:0];

endmodule

`default_nettype wire
